// File: rtl/adc_frame_sync_pkg.sv
// Shared types and helpers for the ADC frame synchroniser.
// Holds the frame FSM state type, the overrun counter width and the word offset helper.
package adc_sync_pkg;

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    localparam int OVR_CNT_W = 16;

    // Bit offset of channel word (adc, ch) inside the packed channel bus.
    function automatic int word_lsb(input int adc, input int ch, input int num_ch, input int data_w);
        return (adc * num_ch + ch) * data_w;
    endfunction

endpackage

// File: rtl/adc_frame_sync_if.sv
// Channel/tick bundle between the DoutReader side and the frame synchroniser.
// The master modport drives the ADC ticks, data and clear; the slave modport drives the frame outputs.
interface adc_frame_sync_if #(
    parameter int NUM_ADC = 2,
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32
);
    import adc_sync_pkg::*;

    logic [NUM_ADC-1:0]                tick_i;
    logic [NUM_ADC*NUM_CH*DATA_W-1:0]  data_i;
    logic                              clear_i;
    logic                              tick_o;
    logic [NUM_ADC*NUM_CH*DATA_W-1:0]  data_o;
    logic [NUM_ADC-1:0]                missing_o;
    logic [NUM_ADC-1:0]                late_o;
    logic                              overrun_o;
    logic [OVR_CNT_W-1:0]              overrun_cnt_o;
    logic                              stale_o;
    logic [CNT_W-1:0]                  frame_cnt_o;

    modport master (
        output tick_i, data_i, clear_i,
        input  tick_o, data_o, missing_o, late_o, overrun_o, overrun_cnt_o, stale_o, frame_cnt_o
    );

    modport slave (
        input  tick_i, data_i, clear_i,
        output tick_o, data_o, missing_o, late_o, overrun_o, overrun_cnt_o, stale_o, frame_cnt_o
    );

endinterface

// File: rtl/adc_frame_sync_timer.sv
// Retriggerable frame delay timer: start arms it, expire is high in its last armed cycle.
// count reads 0 in the cycle after start, so the registered master tick lands DELAY cycles after start.
module frame_delay_timer
    import adc_sync_pkg::*;
#(
    parameter  int DELAY = 100,
    localparam int CW    = $clog2(DELAY)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start,
    output logic          armed,
    output logic          expire,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(DELAY - 2);

    state_t state;

    assign armed  = (state == ARMED);
    assign expire = armed && (count == LAST);

    // A start always wins: it restarts an armed frame and re-arms on the expiry cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            count <= '0;
        end else if (start) begin
            state <= ARMED;
            count <= '0;
        end else if (expire) begin
            state <= IDLE;
            count <= '0;
        end else if (armed) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_sync.sv
// Master tick generator: emits one coherent multi-ADC frame DELAY cycles after the primary tick,
// tracking secondary alignment, overruns and a stale-primary watchdog.
module adc_frame_sync
    import adc_sync_pkg::*;
#(
    parameter int NUM_ADC = 2,
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 32,
    parameter int DELAY   = 100,
    parameter int WINDOW  = 50,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    adc_frame_sync_if.slave bus
);

    localparam int CW   = $clog2(DELAY);
    localparam int WDW  = $clog2(TIMEOUT + 1);
    localparam int TOTW = NUM_ADC * NUM_CH * DATA_W;

    logic                 armed;
    logic                 expire;
    logic [CW-1:0]        count;

    logic [NUM_ADC-1:0]   arrival;
    logic [NUM_ADC-1:0]   pending;
    logic [NUM_ADC-1:0]   hit;
    logic [NUM_ADC-1:0]   late_set;
    logic [NUM_ADC-1:0]   frame_mask;
    logic                 overrun_evt;
    logic [NUM_ADC-1:0]   late_next;
    logic                 overrun_next;
    logic [OVR_CNT_W-1:0] ovr_cnt_next;
    logic [WDW-1:0]       wd_next;

    logic                 tick_q;
    logic [TOTW-1:0]      data_q;
    logic [NUM_ADC-1:0]   missing_q;
    logic [NUM_ADC-1:0]   late_q;
    logic                 overrun_q;
    logic [OVR_CNT_W-1:0] ovr_cnt_q;
    logic                 stale_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic [WDW-1:0]       wd_q;

    frame_delay_timer #(.DELAY(DELAY)) u_timer (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start  (bus.tick_i[0]),
        .armed  (armed),
        .expire (expire),
        .count  (count)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned.
        hit         = '0;
        late_set    = '0;
        pending     = bus.tick_i & ~arrival;
        pending[0]  = 1'b0;
        overrun_evt = armed && !expire && bus.tick_i[0];

        // Secondary ticks only count against a frame that is not being restarted.
        if (armed && !overrun_evt) begin
            if (count < CW'(WINDOW)) hit = pending;
            else                     late_set = pending;
        end
        frame_mask = arrival | hit;

        late_next    = (bus.clear_i ? '0 : late_q) | late_set;
        overrun_next = (bus.clear_i ? 1'b0 : overrun_q) | overrun_evt;
        ovr_cnt_next = bus.clear_i ? '0 : ovr_cnt_q;
        if (overrun_evt && ovr_cnt_next != '1) ovr_cnt_next = ovr_cnt_next + 1'b1;

        if (bus.tick_i[0])              wd_next = '0;
        else if (wd_q == WDW'(TIMEOUT)) wd_next = wd_q;
        else                            wd_next = wd_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the wide snapshot is reset as well, because every output must read zero after reset.
            tick_q      <= 1'b0;
            data_q      <= '0;
            missing_q   <= '0;
            late_q      <= '0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            stale_q     <= 1'b0;
            frame_cnt_q <= '0;
            wd_q        <= '0;
            arrival     <= '0;
        end else begin
            tick_q <= expire;
            if (expire) begin
                for (int a = 0; a < NUM_ADC; a++) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        data_q[word_lsb(a, c, NUM_CH, DATA_W) +: DATA_W] <=
                            bus.data_i[word_lsb(a, c, NUM_CH, DATA_W) +: DATA_W];
                    end
                end
                missing_q   <= ~frame_mask & ~NUM_ADC'(1);
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            // A primary tick (new, restarted or back-to-back frame) re-seeds the arrival mask.
            arrival   <= bus.tick_i[0] ? bus.tick_i : frame_mask;
            late_q    <= late_next;
            overrun_q <= overrun_next;
            ovr_cnt_q <= ovr_cnt_next;
            wd_q      <= wd_next;
            stale_q   <= (wd_next == WDW'(TIMEOUT));
        end
    end

    assign bus.tick_o        = tick_q;
    assign bus.data_o        = data_q;
    assign bus.missing_o     = missing_q;
    assign bus.late_o        = late_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.overrun_cnt_o = ovr_cnt_q;
    assign bus.stale_o       = stale_q;
    assign bus.frame_cnt_o   = frame_cnt_q;

endmodule
